// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - NOR flash READ (0x03) sequencer driving a byte-level SPI master
// Optional SPI_FLASH_WAKE_EN: release-from-power-down (0xAB) plus TRES_CYCLES wait before each read.
module spi_flash_reader #(
    parameter logic [7:0] CMD_READ    = 8'h03,
    parameter int         TRES_CYCLES = 75
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        spi_load,
    output logic [15:0] spi_in,
    input  logic [15:0] spi_out
);

    typedef enum logic [2:0] {
        S_INIT0, S_INIT_POLL, S_IDLE, S_ZERO, S_SEND, S_WAIT1, S_WAIT, S_TRES
    } state_t;

    typedef enum logic [3:0] {
        B_INIT, B_WAKE, B_PD, B_CMD, B_A2, B_A1, B_A0, B_DHI, B_DLO, B_END
    } step_t;

`ifdef SPI_FLASH_WAKE_EN
    localparam step_t FIRST_STEP = B_WAKE;
`else
    localparam step_t FIRST_STEP = B_CMD;
`endif

    state_t      state_q, state_d;
    step_t       step_q, step_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tres_q, tres_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] data_d;
    logic        data_valid_d, done_d, busy_d;
    logic [15:0] cmd_word;
    logic        spi_busy;
    logic        unused_status;

    assign spi_busy      = spi_out[15];
    assign unused_status = ^spi_out[14:8];

    always_comb begin
        cmd_word = 16'h0000;
        case (step_q)
            B_INIT, B_PD, B_END: cmd_word = 16'h0100;
            B_WAKE:              cmd_word = 16'h00AB;
            B_CMD:               cmd_word = {8'h00, CMD_READ};
            B_A2:                cmd_word = {8'h00, addr_q[23:16]};
            B_A1:                cmd_word = {8'h00, addr_q[15:8]};
            B_A0:                cmd_word = {8'h00, addr_q[7:0]};
            default:             cmd_word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT0;
            step_q     <= B_INIT;
            addr_q     <= 24'h0;
            cnt_q      <= 16'h0;
            tres_q     <= 16'h0;
            hi_q       <= 8'h0;
            data       <= 16'h0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            tres_q     <= tres_d;
            hi_q       <= hi_d;
            data       <= data_d;
            data_valid <= data_valid_d;
            done       <= done_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        tres_d       = tres_q;
        hi_d         = hi_q;
        data_d       = data;
        data_valid_d = 1'b0;
        done_d       = 1'b0;
        busy_d       = busy;
        spi_load     = 1'b0;
        spi_in       = 16'h0000;
        case (state_q)
            // A byte may still be in flight from before reset; let it drain first.
            S_INIT0: state_d = S_INIT_POLL;
            S_INIT_POLL: if (!spi_busy) begin
                state_d = S_SEND;
                step_d  = B_INIT;
            end
            S_IDLE: if (start) begin
                addr_d = addr;
                cnt_d  = len;
                busy_d = 1'b1;
                if (len == 16'h0) begin
                    state_d = S_ZERO;
                end else begin
                    state_d = S_SEND;
                    step_d  = FIRST_STEP;
                end
            end
            S_ZERO: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_SEND: begin
                spi_load = 1'b1;
                spi_in   = cmd_word;
                state_d  = S_WAIT1;
            end
            S_WAIT1: state_d = S_WAIT;
            S_WAIT: if (!spi_busy) begin
                state_d = S_SEND;
                case (step_q)
                    B_INIT: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                    B_WAKE: step_d = B_PD;
                    B_PD: begin
                        state_d = S_TRES;
                        tres_d  = 16'(TRES_CYCLES);
                    end
                    B_CMD:  step_d = B_A2;
                    B_A2:   step_d = B_A1;
                    B_A1:   step_d = B_A0;
                    B_A0:   step_d = B_DHI;
                    B_DHI: begin
                        hi_d   = spi_out[7:0];
                        step_d = B_DLO;
                    end
                    B_DLO: begin
                        data_d       = {hi_q, spi_out[7:0]};
                        data_valid_d = 1'b1;
                        cnt_d        = cnt_q - 16'h1;
                        step_d       = (cnt_q == 16'h1) ? B_END : B_DHI;
                    end
                    B_END: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                    default: state_d = S_INIT0;
                endcase
            end
            S_TRES: begin
                if (tres_q <= 16'h1) begin
                    state_d = S_SEND;
                    step_d  = B_CMD;
                end else begin
                    tres_d = tres_q - 16'h1;
                end
            end
            default: state_d = S_INIT0;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - scoreboard bench for spi_flash_reader with SPI master + flash model
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [15:0] len = 16'h0;
    logic        busy, done, data_valid, spi_load;
    logic [15:0] data, spi_in, spi_out;

    spi_flash_reader #(.CMD_READ(8'h03), .TRES_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .data(data), .data_valid(data_valid),
        .spi_load(spi_load), .spi_in(spi_in), .spi_out(spi_out)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_loads = 0;
    int n_done = 0;
    logic [15:0] exp_loads[$];
    logic [15:0] exp_words[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h020000: return 8'h12;
            24'h020001: return 8'h34;
            24'h020002: return 8'h56;
            24'h020003: return 8'h78;
            default:    return a[7:0] ^ a[15:8] ^ 8'h3C;
        endcase
    endfunction

    // SPI master + flash: 8 busy cycles per load, received byte ready when busy drops
    logic [4:0]  sp_cnt = 5'd0;
    logic [7:0]  sp_rx = 8'h0;
    int          fl_idx = 0;
    logic [23:0] fl_addr = 24'h0;
    assign spi_out = {(sp_cnt != 5'd0), 7'h0, sp_rx};

    always @(posedge clk) begin
        if (sp_cnt != 5'd0) sp_cnt <= sp_cnt - 5'd1;
        if (spi_load) begin
            sp_cnt <= 5'd8;
            if (spi_in[8]) begin
                fl_idx <= 0;
            end else begin
                fl_idx <= fl_idx + 1;
                if (fl_idx >= 1 && fl_idx <= 3) begin
                    fl_addr <= {fl_addr[15:0], spi_in[7:0]};
                    sp_rx   <= 8'h00;
                end else if (fl_idx >= 4) begin
                    sp_rx   <= fbyte(fl_addr);
                    fl_addr <= fl_addr + 24'd1;
                end else begin
                    sp_rx <= 8'h00;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (spi_load) begin
            n_loads++;
            check("load_while_busy", {31'h0, spi_out[15]}, 32'h0);
            check("load_expected", {31'h0, exp_loads.size() != 0}, 32'h1);
            if (exp_loads.size() != 0) check("load_value", {16'h0, spi_in}, {16'h0, exp_loads.pop_front()});
        end
        if (data_valid) begin
            check("word_expected", {31'h0, exp_words.size() != 0}, 32'h1);
            if (exp_words.size() != 0) check("word_value", {16'h0, data}, {16'h0, exp_words.pop_front()});
        end
        if (done) begin
            n_done++;
            check("done_dv_excl", {31'h0, data_valid}, 32'h0);
        end
    end

    task automatic push_read(input logic [23:0] a, input logic [15:0] n);
`ifdef SPI_FLASH_WAKE_EN
        exp_loads.push_back(16'h00AB);
        exp_loads.push_back(16'h0100);
`endif
        exp_loads.push_back(16'h0003);
        exp_loads.push_back({8'h00, a[23:16]});
        exp_loads.push_back({8'h00, a[15:8]});
        exp_loads.push_back({8'h00, a[7:0]});
        for (int i = 0; i < 2 * int'(n); i++) exp_loads.push_back(16'h0000);
        exp_loads.push_back(16'h0100);
        for (int i = 0; i < int'(n); i++)
            exp_words.push_back({fbyte(a + 24'(2 * i)), fbyte(a + 24'(2 * i + 1))});
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        addr  = a;
        len   = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int c = 0;
        while (busy && c < limit) begin
            @(negedge clk);
            c++;
        end
        check(tag, {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_done(input string tag, input int limit, output int cycles);
        cycles = 1;
        while (!done && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, {31'h0, done}, 32'h1);
    endtask

    int cyc, l0, d0;

    initial begin
        // reset state
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_dv", {31'h0, data_valid}, 32'h0);
        check("rst_load", {31'h0, spi_load}, 32'h0);
        check("rst_spi_in", {16'h0, spi_in}, 32'h0);
        check("rst_data", {16'h0, data}, 32'h0);
        exp_loads.push_back(16'h0100);
        rst = 1'b0;
        wait_idle("init_idle", 200);
        check("init_loads", n_loads, 1);
        check("init_q_empty", exp_loads.size(), 0);

        // basic read with fixed flash contents
        push_read(24'h020000, 16'd2);
        d0 = n_done;
        pulse_start(24'h020000, 16'd2);
        wait_done("read2_done", 2000, cyc);
        check("read2_min_time", {31'h0, cyc + 1 >= 90}, 32'h1);
        repeat (3) @(negedge clk);
        check("read2_done_cnt", n_done - d0, 1);
        check("read2_loads_left", exp_loads.size(), 0);
        check("read2_words_left", exp_words.size(), 0);
        check("read2_busy", {31'h0, busy}, 32'h0);

        // len = 0: done one cycle later, no SPI traffic
        l0 = n_loads;
        @(negedge clk);
        start = 1'b1; addr = 24'h001234; len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_busy", {31'h0, busy}, 32'h1);
        check("len0_nodone", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("len0_done", {31'h0, done}, 32'h1);
        check("len0_busy_fall", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("len0_done_pulse", {31'h0, done}, 32'h0);
        check("len0_loads", n_loads - l0, 0);

        // start while busy is ignored
        push_read(24'h000100, 16'd3);
        pulse_start(24'h000100, 16'd3);
        repeat (25) @(negedge clk);
        start = 1'b1; addr = 24'hFFFFFF; len = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done", 4000, cyc);
        repeat (3) @(negedge clk);
        check("ign_loads_left", exp_loads.size(), 0);
        check("ign_words_left", exp_words.size(), 0);

        // async reset during DLO of word 1
        push_read(24'h000400, 16'd3);
        l0 = n_loads;
        pulse_start(24'h000400, 16'd3);
        cyc = 0;
`ifdef SPI_FLASH_WAKE_EN
        while (n_loads - l0 < 8 && cyc < 2000) begin @(negedge clk); cyc++; end
`else
        while (n_loads - l0 < 6 && cyc < 2000) begin @(negedge clk); cyc++; end
`endif
        check("rst_mid_reached", {31'h0, cyc < 2000}, 32'h1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstm_busy", {31'h0, busy}, 32'h1);
        check("rstm_dv", {31'h0, data_valid}, 32'h0);
        check("rstm_load", {31'h0, spi_load}, 32'h0);
        check("rstm_done", {31'h0, done}, 32'h0);
        exp_loads.delete();
        exp_words.delete();
        exp_loads.push_back(16'h0100);
        l0 = n_loads;
        @(negedge clk);
        rst = 1'b0;
        wait_idle("rstm_idle", 200);
        check("rstm_loads", n_loads - l0, 1);
        push_read(24'h020000, 16'd2);
        pulse_start(24'h020000, 16'd2);
        wait_done("post_rst_done", 2000, cyc);
        repeat (3) @(negedge clk);
        check("post_rst_loads_left", exp_loads.size(), 0);
        check("post_rst_words_left", exp_words.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
